// File: rtl/decoder_scan_nbit.sv
// Registered N-bit active-low decoder with G1/G2A_N/G2B_N gating and an auto-scan mode.
// Optional macro DECODER_SCAN_BLANK_EN inserts a one-cycle all-high gap on every scan advance.
module decoder_scan_nbit #(
    parameter  int SEL_W    = 3,
    parameter  int N_ACTIVE = 8,
    parameter  int PRESCALE = 100000,
    parameter  int PS_W     = 17,
    localparam int OUT_W    = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g1,
    input  logic             g2a_n,
    input  logic             g2b_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] x,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             step
);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_ACTIVE - 1);

    logic [OUT_W-1:0] r_y;
    logic [SEL_W-1:0] r_idx;
    logic [PS_W-1:0]  r_ps;
    logic             r_step;
    logic             r_mode_q;

    logic             w_en;
    logic             w_entry;
    logic             w_tc;
    logic [SEL_W-1:0] w_idx_inc;
    logic [OUT_W-1:0] w_y_d;
    logic [SEL_W-1:0] w_idx_d;
    logic [PS_W-1:0]  w_ps_d;
    logic             w_step_d;

    function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] k);
        return ~(OUT_W'(1) << k);
    endfunction

    assign w_en      = g1 & ~g2a_n & ~g2b_n;
    assign w_entry   = mode & ~r_mode_q;
    assign w_tc      = (r_ps == PS_LAST);
    assign w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + SEL_W'(1);

    // NOTE: next-state is computed combinationally with a default for every signal
    // first, so no path through the if/else can leave a value unassigned (no latch).
    always_comb begin
        w_y_d    = '1;
        w_idx_d  = r_idx;
        w_ps_d   = r_ps;
        w_step_d = 1'b0;
        if (!mode) begin
            if (w_en) begin
                w_y_d = dec(x);
            end
        end else if (w_entry) begin
            // Scan always starts from output 0, whatever the enables are doing.
            w_ps_d  = '0;
            w_idx_d = '0;
            if (w_en) begin
                w_y_d = dec('0);
            end
        end else if (w_en) begin
            if (w_tc) begin
                w_ps_d   = '0;
                w_idx_d  = w_idx_inc;
                w_step_d = 1'b1;
`ifdef DECODER_SCAN_BLANK_EN
                w_y_d    = '1;
`else
                w_y_d    = dec(w_idx_inc);
`endif
            end else begin
                w_ps_d = r_ps + PS_W'(1);
                w_y_d  = dec(r_idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and every register
    // here is reset asynchronously so the select lines go inactive without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= '1;
            r_idx    <= '0;
            r_ps     <= '0;
            r_step   <= 1'b0;
            r_mode_q <= 1'b0;
        end else begin
            r_y      <= w_y_d;
            r_idx    <= w_idx_d;
            r_ps     <= w_ps_d;
            r_step   <= w_step_d;
            r_mode_q <= mode;
        end
    end

    assign y    = r_y;
    assign idx  = r_idx;
    assign step = r_step;

endmodule
